// File: rtl/si_channel_arbiter_if.sv
// Upstream channels and the merged downstream AXI-Stream of si_channel_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface si_channel_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]              s_tvalid;
    logic [NUM_CH-1:0]              s_tready;
    logic [NUM_CH*DATA_WIDTH-1:0]   s_tdata;
    logic [NUM_CH*DATA_WIDTH/8-1:0] s_tkeep;
    logic [NUM_CH-1:0]              s_tlast;
    logic [NUM_CH*USER_WIDTH-1:0]   s_tuser;

    logic                           m_tvalid;
    logic                           m_tready;
    logic [DATA_WIDTH-1:0]          m_tdata;
    logic [DATA_WIDTH/8-1:0]        m_tkeep;
    logic                           m_tlast;
    logic [USER_WIDTH-1:0]          m_tuser;
    logic [ID_WIDTH-1:0]            m_tid;

    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_tid
    );

    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_tid
    );
endinterface

// File: rtl/si_channel_arbiter.sv
// Packet-granular round-robin merge of NUM_CH AXI-Stream tag channels into one stream,
// with per-channel enable, source id on m_tid and per-channel completed-packet counters.
module si_channel_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int ID_WIDTH   = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           ch_enable,
    input  logic                        cnt_clear,
    si_channel_arbiter_if.slave         bus,
    output logic [NUM_CH*CNT_WIDTH-1:0] pkt_count,
    output logic                        busy
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PASS = 1'b1;

    logic [0:0]            state_reg;
    logic [ID_WIDTH-1:0]   grant_reg;
    logic [ID_WIDTH-1:0]   ptr_reg;
    logic                  m_tvalid_reg;
    logic [DATA_WIDTH-1:0] m_tdata_reg;
    logic [KEEP_WIDTH-1:0] m_tkeep_reg;
    logic                  m_tlast_reg;
    logic [USER_WIDTH-1:0] m_tuser_reg;
    logic [ID_WIDTH-1:0]   m_tid_reg;

    logic                  out_ready;
    logic                  accept;
    logic                  sel_last;
    logic [NUM_CH-1:0]     candidates;
    logic [2*NUM_CH-1:0]   cand_dbl;
    logic [NUM_CH-1:0]     cand_rot;
    logic                  found;
    logic [ID_WIDTH:0]     pick_sum;
    logic [ID_WIDTH-1:0]   pick;
    logic [ID_WIDTH-1:0]   ptr_next;
    logic [NUM_CH-1:0]     ready_vec;

    assign out_ready  = !m_tvalid_reg || bus.m_tready;
    assign sel_last   = bus.s_tlast[grant_reg];
    assign accept     = (state_reg == PASS) && bus.s_tvalid[grant_reg] && out_ready;
    assign candidates = bus.s_tvalid & ch_enable;
    assign found      = |candidates;

    // Rotate the candidate vector so bit 0 is the channel under the pointer;
    // the lowest set bit of the rotated vector is then the round-robin winner.
    assign cand_dbl = {candidates, candidates};
    assign cand_rot = cand_dbl[ptr_reg +: NUM_CH];

    always_comb begin
        pick_sum = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (cand_rot[k]) begin
                pick_sum = {1'b0, ptr_reg} + (ID_WIDTH+1)'(k);
            end
        end
        if (pick_sum >= (ID_WIDTH+1)'(NUM_CH)) begin
            pick_sum = pick_sum - (ID_WIDTH+1)'(NUM_CH);
        end
        pick = pick_sum[ID_WIDTH-1:0];
    end

    assign ptr_next = (grant_reg == ID_WIDTH'(NUM_CH - 1)) ? '0 : grant_reg + ID_WIDTH'(1);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
            assign ready_vec[gi] = (state_reg == PASS) && (grant_reg == ID_WIDTH'(gi)) && out_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            ptr_reg      <= '0;
            m_tvalid_reg <= 1'b0;
            m_tdata_reg  <= '0;
            m_tkeep_reg  <= '0;
            m_tlast_reg  <= 1'b0;
            m_tuser_reg  <= '0;
            m_tid_reg    <= '0;
        end else begin
            if (accept) begin
                m_tvalid_reg <= 1'b1;
                m_tdata_reg  <= bus.s_tdata[grant_reg*DATA_WIDTH +: DATA_WIDTH];
                m_tkeep_reg  <= bus.s_tkeep[grant_reg*KEEP_WIDTH +: KEEP_WIDTH];
                m_tlast_reg  <= sel_last;
                m_tuser_reg  <= bus.s_tuser[grant_reg*USER_WIDTH +: USER_WIDTH];
                m_tid_reg    <= grant_reg;
            end else if (bus.m_tready) begin
                m_tvalid_reg <= 1'b0;
            end

            if (state_reg == IDLE) begin
                if (found) begin
                    grant_reg <= pick;
                    state_reg <= PASS;
                end
            end else if (accept && sel_last) begin
                ptr_reg   <= ptr_next;
                state_reg <= IDLE;
            end
        end
    end

    // Clear takes priority over a coincident end-of-packet increment.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_clear) begin
                    cnt_reg <= '0;
                end else if (accept && sel_last && (grant_reg == ID_WIDTH'(gi))) begin
                    cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                end
            end
            assign pkt_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
        end
    endgenerate

    assign bus.s_tready = ready_vec;
    assign bus.m_tvalid = m_tvalid_reg;
    assign bus.m_tdata  = m_tdata_reg;
    assign bus.m_tkeep  = m_tkeep_reg;
    assign bus.m_tlast  = m_tlast_reg;
    assign bus.m_tuser  = m_tuser_reg;
    assign bus.m_tid    = m_tid_reg;
    assign busy         = (state_reg == PASS);
endmodule
